clause_gather: RTL and testbench
================================

CLAUSE_GATHER -- requirements
Module: clause_gather

Interface
REQ-001 Parameter CLAUSE_COUNT, default 20: number of slots in the output bundle.
REQ-002 Parameter CLAUSE_WIDTH, default 36: bits per clause.
REQ-003 Parameter FLUSH_TIMEOUT, default 8: idle cycles after which a partial bundle is emitted; 0 disables the timeout.
REQ-004 The module SHALL use one clock; reset is asynchronous and active-low.
REQ-005 Port clk, input, 1: the only clock; all state updates on the rising edge.
REQ-006 Port reset, input, 1: asynchronous, active-low reset.
REQ-007 Port clause_i, input, CLAUSE_WIDTH: incoming serial clause.
REQ-008 Port clause_valid_i, input, 1: clause_i is valid this cycle.
REQ-009 Port clause_ready_o, output, 1: the module accepts clause_i this cycle.
REQ-010 Port flush_i, input, 1: emit the current partial bundle.
REQ-011 Port clauses_o, output, CLAUSE_WIDTH*CLAUSE_COUNT: bundle; slot k occupies bits [k*CLAUSE_WIDTH +: CLAUSE_WIDTH].
REQ-012 Port clause_valid_o, output, CLAUSE_COUNT: per-slot valid mask.
REQ-013 Port bundle_valid_o, output, 1: the bundle is presented.
REQ-014 Port bundle_ready_i, input, 1: downstream accepts the bundle.
REQ-015 Port fill_count_o, output, clog2(CLAUSE_COUNT+1): number of occupied slots.

Function
REQ-016 An accept SHALL occur on a rising edge where clause_valid_i and clause_ready_o are both high.
REQ-017 A bundle transfer SHALL occur on a rising edge where bundle_valid_o and bundle_ready_i are both high.
REQ-018 FSM states SHALL be exactly two:
- FILL: clause_ready_o=1, bundle_valid_o=0.
- HOLD: clause_ready_o=0, bundle_valid_o=1.
REQ-019 In FILL, an accept SHALL write clause_i into slot fill_count_o, set that bit of clause_valid_o, and increment fill_count_o, all in the same edge.
REQ-020 Slots SHALL fill in ascending order from 0; there are no gaps in clause_valid_o.
REQ-021 FILL->HOLD SHALL occur on the edge where the accept fills slot CLAUSE_COUNT-1, so bundle_valid_o rises one cycle after the final accept.
REQ-022 FILL->HOLD SHALL occur on an edge where flush_i=1 and fill_count_o>0.
- If an accept occurs on the same edge, that clause is included in the emitted bundle.
REQ-023 flush_i SHALL be ignored while fill_count_o=0 with no accept on the same edge; flush_i is also ignored in HOLD.
REQ-024 Timeout counter:
- Increments each FILL cycle with fill_count_o>0 and no accept.
- Clears on any accept or on entry to FILL.
- Reaching FLUSH_TIMEOUT SHALL cause FILL->HOLD.
REQ-025 While in HOLD, clauses_o, clause_valid_o and fill_count_o SHALL hold stable until the bundle transfer.
REQ-026 On a bundle transfer, the FSM SHALL return to FILL and clear clause_valid_o, fill_count_o and the timeout counter on that edge; the first new accept is possible on the next cycle.
REQ-027 Contents of unused slots in clauses_o are don't-care; downstream qualifies them with clause_valid_o.
REQ-028 bundle_valid_o SHALL NOT depend combinationally on bundle_ready_i, and clause_ready_o SHALL NOT depend combinationally on clause_valid_i.

Reset
REQ-029 Asserting reset SHALL immediately force:
- State FILL.
- clause_valid_o=0, fill_count_o=0, bundle_valid_o=0, timeout counter 0.
- clause_ready_o=1 once reset deasserts.
REQ-030 Reset asserted mid-fill or in HOLD SHALL discard the partial or pending bundle without emitting it.
REQ-031 clauses_o data registers need not be reset.

Structure
REQ-032 CLAUSE_WIDTH and CLAUSE_COUNT defaults and the FSM state typedef SHALL live in shared package sat_pkg, shared with the FIFO tree.
REQ-033 The design SHALL be a single module with no sub-module; slot storage is a register array indexed by fill_count_o.

Verification
REQ-034 Scenario: 20 back-to-back accepts with values 1..20, bundle_ready_i=1 -> bundle_valid_o high for 1 cycle, 1 cycle after the last accept; clause_valid_o=20'hFFFFF; slot k = k+1.
REQ-035 Scenario: 5 accepts, then flush_i pulse -> next cycle bundle_valid_o=1, clause_valid_o=20'h0001F, fill_count_o=5.
REQ-036 Scenario: 3 accepts, then idle with FLUSH_TIMEOUT=8 -> bundle_valid_o rises exactly 9 cycles after the last accept, clause_valid_o=20'h00007.
REQ-037 Scenario: full bundle with bundle_ready_i=0 for 10 cycles and clause_valid_i held at 1 -> clause_ready_o=0 throughout, bundle stable; after ready, the next bundle starts at slot 0.
REQ-038 Scenario: flush_i on the same edge as the 4th accept -> bundle holds 4 clauses; flush_i with an empty bundle -> no bundle emitted.
REQ-039 Scenario: reset asserted in HOLD with 7 clauses pending -> outputs cleared asynchronously; after release, 20 fresh accepts yield a bundle containing only the new data.

Source files
------------

// File: rtl/sat_pkg.sv
// Shared definitions for the clause-handling datapath (gather stage and FIFO tree).
package sat_pkg;

  localparam int unsigned CLAUSE_WIDTH_DEF = 36;
  localparam int unsigned CLAUSE_COUNT_DEF = 20;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } gather_state_e;

  // Width able to represent values 0..max inclusive, never narrower than 1 bit.
  function automatic int unsigned count_width(input int unsigned max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage : sat_pkg

// File: rtl/clause_gather.sv
// Gathers serial clauses into a parallel bundle; emits when full, on flush, or after idle timeout.
module clause_gather
  import sat_pkg::*;
#(
  parameter int unsigned CLAUSE_COUNT  = CLAUSE_COUNT_DEF,
  parameter int unsigned CLAUSE_WIDTH  = CLAUSE_WIDTH_DEF,
  parameter int unsigned FLUSH_TIMEOUT = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [CLAUSE_WIDTH-1:0]              clause_i,
  input  logic                                 clause_valid_i,
  output logic                                 clause_ready_o,
  input  logic                                 flush_i,
  output logic [CLAUSE_WIDTH*CLAUSE_COUNT-1:0] clauses_o,
  output logic [CLAUSE_COUNT-1:0]              clause_valid_o,
  output logic                                 bundle_valid_o,
  input  logic                                 bundle_ready_i,
  output logic [$clog2(CLAUSE_COUNT+1)-1:0]    fill_count_o
);

  localparam int unsigned FCW = $clog2(CLAUSE_COUNT + 1);
  localparam int unsigned TW  = count_width(FLUSH_TIMEOUT);

  gather_state_e           state_q, state_d;
  logic [FCW-1:0]          fill_q, fill_d;
  logic [CLAUSE_COUNT-1:0] valid_q, valid_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [CLAUSE_WIDTH-1:0] slots_q [CLAUSE_COUNT];
  logic [CLAUSE_WIDTH-1:0] slots_d [CLAUSE_COUNT];
  logic                    accept;

  assign clause_ready_o = (state_q == ST_FILL);
  assign bundle_valid_o = (state_q == ST_HOLD);
  assign clause_valid_o = valid_q;
  assign fill_count_o   = fill_q;
  assign accept         = clause_ready_o && clause_valid_i;

  // Next-state: slot write, fill/timeout bookkeeping and FILL/HOLD transitions.
  // The timeout fires on the idle cycle after the counter has already reached
  // FLUSH_TIMEOUT, so the bundle appears FLUSH_TIMEOUT+1 cycles after the last accept.
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    valid_d = valid_q;
    timer_d = timer_q;
    slots_d = slots_q;
    unique case (state_q)
      ST_FILL: begin
        if (accept) begin
          for (int unsigned k = 0; k < CLAUSE_COUNT; k++) begin
            if (fill_q == FCW'(k)) begin
              slots_d[k] = clause_i;
              valid_d[k] = 1'b1;
            end
          end
          fill_d  = fill_q + FCW'(1);
          timer_d = '0;
          if (fill_q == FCW'(CLAUSE_COUNT - 1) || flush_i) begin
            state_d = ST_HOLD;
          end
        end else if (fill_q != '0) begin
          if (flush_i) begin
            state_d = ST_HOLD;
          end else if (FLUSH_TIMEOUT != 0) begin
            if (timer_q == TW'(FLUSH_TIMEOUT)) begin
              state_d = ST_HOLD;
            end else begin
              timer_d = timer_q + TW'(1);
            end
          end
        end
      end
      ST_HOLD: begin
        if (bundle_ready_i) begin
          state_d = ST_FILL;
          fill_d  = '0;
          valid_d = '0;
          timer_d = '0;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_FILL;
      fill_q  <= '0;
      valid_q <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      valid_q <= valid_d;
      timer_q <= timer_d;
    end
  end

  // Slot data storage; qualified by valid_q so it needs no reset.
  always_ff @(posedge clk) begin
    slots_q <= slots_d;
  end

  // Flatten slot array onto the bundle bus.
  always_comb begin
    clauses_o = '0;
    for (int unsigned k = 0; k < CLAUSE_COUNT; k++) begin
      clauses_o[k*CLAUSE_WIDTH +: CLAUSE_WIDTH] = slots_q[k];
    end
  end

endmodule : clause_gather

// File: tb/tb_clause_gather.sv
// Directed self-checking bench for clause_gather at default parameters.
module tb_clause_gather;

  localparam int CC = 20;
  localparam int CW = 36;

  logic              clk;
  logic              reset;
  logic [CW-1:0]     clause_i;
  logic              clause_valid_i;
  logic              clause_ready_o;
  logic              flush_i;
  logic [CW*CC-1:0]  clauses_o;
  logic [CC-1:0]     clause_valid_o;
  logic              bundle_valid_o;
  logic              bundle_ready_i;
  logic [4:0]        fill_count_o;

  int n_checks = 0;
  int n_errors = 0;

  clause_gather #(
    .CLAUSE_COUNT (CC),
    .CLAUSE_WIDTH (CW),
    .FLUSH_TIMEOUT(8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .clause_i      (clause_i),
    .clause_valid_i(clause_valid_i),
    .clause_ready_o(clause_ready_o),
    .flush_i       (flush_i),
    .clauses_o     (clauses_o),
    .clause_valid_o(clause_valid_o),
    .bundle_valid_o(bundle_valid_o),
    .bundle_ready_i(bundle_ready_i),
    .fill_count_o  (fill_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] slot(input int k);
    return clauses_o[k*CW +: CW];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_n(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      clause_valid_i = 1'b1;
      clause_i       = CW'(base + i);
      step();
    end
    clause_valid_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b0;
    clause_i       = '0;
    clause_valid_i = 1'b0;
    flush_i        = 1'b0;
    bundle_ready_i = 1'b1;
    #2;
    check("rst_bv", 64'(bundle_valid_o), 64'd0);
    check("rst_fill", 64'(fill_count_o), 64'd0);
    check("rst_mask", 64'(clause_valid_o), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("rst_ready", 64'(clause_ready_o), 64'd1);

    // Full bundle, values 1..20
    accept_n(19, 1);
    check("full_bv19", 64'(bundle_valid_o), 64'd0);
    check("full_fill19", 64'(fill_count_o), 64'd19);
    accept_n(1, 20);
    check("full_bv", 64'(bundle_valid_o), 64'd1);
    check("full_mask", 64'(clause_valid_o), 64'hFFFFF);
    check("full_fill", 64'(fill_count_o), 64'd20);
    for (int k = 0; k < CC; k++) check($sformatf("full_slot%0d", k), 64'(slot(k)), 64'(k + 1));
    step();
    check("full_bv_drop", 64'(bundle_valid_o), 64'd0);
    check("full_fill_clr", 64'(fill_count_o), 64'd0);

    // Explicit flush after 5
    accept_n(5, 100);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check("fl_bv", 64'(bundle_valid_o), 64'd1);
    check("fl_mask", 64'(clause_valid_o), 64'h0001F);
    check("fl_fill", 64'(fill_count_o), 64'd5);
    check("fl_slot4", 64'(slot(4)), 64'd104);
    step();
    check("fl_bv_drop", 64'(bundle_valid_o), 64'd0);

    // Idle timeout after 3
    accept_n(3, 50);
    repeat (8) step();
    check("to_bv8", 64'(bundle_valid_o), 64'd0);
    step();
    check("to_bv9", 64'(bundle_valid_o), 64'd1);
    check("to_mask", 64'(clause_valid_o), 64'h00007);
    step();
    check("to_bv_drop", 64'(bundle_valid_o), 64'd0);

    // Backpressure with valid held high
    bundle_ready_i = 1'b0;
    accept_n(20, 200);
    clause_valid_i = 1'b1;
    clause_i       = CW'(999);
    for (int c = 0; c < 10; c++) begin
      check("bp_ready", 64'(clause_ready_o), 64'd0);
      check("bp_bv", 64'(bundle_valid_o), 64'd1);
      check("bp_slot19", 64'(slot(19)), 64'd219);
      check("bp_fill", 64'(fill_count_o), 64'd20);
      step();
    end
    bundle_ready_i = 1'b1;
    step();
    check("bp_bv_drop", 64'(bundle_valid_o), 64'd0);
    check("bp_fill_clr", 64'(fill_count_o), 64'd0);
    clause_i = CW'(500);
    step();
    clause_valid_i = 1'b0;
    check("bp_next_fill", 64'(fill_count_o), 64'd1);
    check("bp_next_slot0", 64'(slot(0)), 64'd500);
    check("bp_next_mask", 64'(clause_valid_o), 64'h00001);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check("bp_fl_bv", 64'(bundle_valid_o), 64'd1);
    step();

    // Flush coinciding with 4th accept, then flush on empty
    accept_n(3, 300);
    clause_valid_i = 1'b1;
    clause_i       = CW'(303);
    flush_i        = 1'b1;
    step();
    clause_valid_i = 1'b0;
    flush_i        = 1'b0;
    check("cf_bv", 64'(bundle_valid_o), 64'd1);
    check("cf_fill", 64'(fill_count_o), 64'd4);
    check("cf_mask", 64'(clause_valid_o), 64'h0000F);
    check("cf_slot3", 64'(slot(3)), 64'd303);
    step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check("ef_bv", 64'(bundle_valid_o), 64'd0);
    check("ef_fill", 64'(fill_count_o), 64'd0);
    step();
    check("ef_bv2", 64'(bundle_valid_o), 64'd0);

    // Reset while holding 7 pending
    bundle_ready_i = 1'b0;
    accept_n(7, 400);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check("rh_bv", 64'(bundle_valid_o), 64'd1);
    check("rh_fill", 64'(fill_count_o), 64'd7);
    #1 reset = 1'b0;
    #1;
    check("rh_bv_clr", 64'(bundle_valid_o), 64'd0);
    check("rh_fill_clr", 64'(fill_count_o), 64'd0);
    check("rh_mask_clr", 64'(clause_valid_o), 64'd0);
    step();
    #1 reset = 1'b1;
    bundle_ready_i = 1'b1;
    accept_n(20, 600);
    check("rh_new_bv", 64'(bundle_valid_o), 64'd1);
    check("rh_new_mask", 64'(clause_valid_o), 64'hFFFFF);
    check("rh_new_slot0", 64'(slot(0)), 64'd600);
    check("rh_new_slot6", 64'(slot(6)), 64'd606);
    check("rh_new_slot19", 64'(slot(19)), 64'd619);
    step();
    check("rh_new_drop", 64'(bundle_valid_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_clause_gather
